// File: rtl/reorder_buffer_pkg.sv
// -----------------------------------------------------------------------------
// reorder_buffer_pkg
// Shared sizing for the reorder buffer and its users: default entry count and
// the physical register file sizes that set the widths of the freed-register
// addresses returned at commit.
// -----------------------------------------------------------------------------
package reorder_buffer_pkg;

  localparam int NUM_ROB_ENTRIES = 8;
  localparam int NUM_D_REG       = 32;
  localparam int NUM_S_REG       = 16;

  localparam int D_ADDR_W = $clog2(NUM_D_REG);
  localparam int S_ADDR_W = $clog2(NUM_S_REG);

  typedef logic [D_ADDR_W-1:0] d_reg_addr_t;
  typedef logic [S_ADDR_W-1:0] s_reg_addr_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// -----------------------------------------------------------------------------
// reorder_buffer_if
// Bundles the dispatch (allocate), completion, commit and status signals of the
// reorder buffer.
//   master : core side - drives flush, alloc_* requests and complete_* tags,
//            observes alloc_ready/alloc_rob_addr, commit_* and status.
//   slave  : the reorder buffer itself.
// Parameter L is the entry count and must match the attached reorder_buffer.
// -----------------------------------------------------------------------------
interface reorder_buffer_if
  import reorder_buffer_pkg::*;
#(
  parameter int L = NUM_ROB_ENTRIES
);

  localparam int TAG_W = $clog2(L);

  logic              flush;

  logic              alloc_valid;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_rob_addr;
  logic              alloc_write_dst;
  d_reg_addr_t       alloc_prev_rw_addr;
  logic              alloc_write_s;
  s_reg_addr_t       alloc_prev_rs_addr;

  logic              complete_valid;
  logic [TAG_W-1:0]  complete_rob_addr;

  logic              commit_valid;
  logic              commit_free_d;
  d_reg_addr_t       commit_free_d_addr;
  logic              commit_free_s;
  s_reg_addr_t       commit_free_s_addr;

  logic              empty;
  logic [TAG_W:0]    count;

  modport master (
    output flush,
    output alloc_valid, alloc_write_dst, alloc_prev_rw_addr,
    output alloc_write_s, alloc_prev_rs_addr,
    input  alloc_ready, alloc_rob_addr,
    output complete_valid, complete_rob_addr,
    input  commit_valid, commit_free_d, commit_free_d_addr,
    input  commit_free_s, commit_free_s_addr,
    input  empty, count
  );

  modport slave (
    input  flush,
    input  alloc_valid, alloc_write_dst, alloc_prev_rw_addr,
    input  alloc_write_s, alloc_prev_rs_addr,
    output alloc_ready, alloc_rob_addr,
    input  complete_valid, complete_rob_addr,
    output commit_valid, commit_free_d, commit_free_d_addr,
    output commit_free_s, commit_free_s_addr,
    output empty, count
  );

endinterface

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
// In-order retirement tracker. Dispatch allocates the entry at the tail and gets
// its tag back combinationally; completion marks an entry done by tag; the head
// entry retires (at most one per cycle) once done, handing its previous D/S
// physical mappings back to the free lists.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (same effect as flush)
//   rob  - reorder_buffer_if.slave: flush, alloc_*, complete_*, commit_*,
//          empty, count
// -----------------------------------------------------------------------------
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int L = NUM_ROB_ENTRIES
)(
  input  logic clk,
  input  logic rst,
  reorder_buffer_if.slave rob
);

  localparam int TAG_W = $clog2(L);
  localparam int CNT_W = TAG_W + 1;

  // Payload kept separately from valid/done so only the control bits are reset.
  typedef struct packed {
    logic        write_dst;
    d_reg_addr_t prev_rw_addr;
    logic        write_s;
    s_reg_addr_t prev_rs_addr;
  } rob_entry_t;

  logic [L-1:0]     r_valid;
  logic [L-1:0]     r_done;
  rob_entry_t       r_entry [L];
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic       w_ready;
  logic       w_alloc;
  logic       w_complete;
  logic       w_commit;
  rob_entry_t w_head_entry;

  // Readiness ignores a same-cycle commit: a full buffer refuses dispatch even
  // while it retires, which keeps this off the commit timing path.
  assign w_ready      = (r_count != CNT_W'(L));
  assign w_alloc      = rob.alloc_valid & w_ready & ~rob.flush;
  assign w_complete   = rob.complete_valid & ~rob.flush & r_valid[rob.complete_rob_addr];
  assign w_head_entry = r_entry[r_head];
  assign w_commit     = r_valid[r_head] & r_done[r_head] & ~rob.flush;

  // Control state: pointers, occupancy and per-entry valid/done.
  always_ff @(posedge clk) begin
    if (rst || rob.flush) begin
      r_valid <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // The tail slot is never valid while allocation is possible, so the
      // alloc write and a completion can never target the same entry.
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_complete) begin
        r_done[rob.complete_rob_addr] <= 1'b1;
      end
      if (w_commit) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_commit);
    end
  end

  // Payload capture at allocation; contents of invalid slots are don't-care.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_entry[r_tail] <= '{write_dst:    rob.alloc_write_dst,
                           prev_rw_addr: rob.alloc_prev_rw_addr,
                           write_s:      rob.alloc_write_s,
                           prev_rs_addr: rob.alloc_prev_rs_addr};
    end
  end

  assign rob.alloc_ready    = w_ready;
  assign rob.alloc_rob_addr = r_tail;
  assign rob.empty          = (r_count == '0);
  assign rob.count          = r_count;

  // Addresses are forced to zero outside a commit so the unreset payload never
  // shows on the outputs.
  assign rob.commit_valid       = w_commit;
  assign rob.commit_free_d      = w_commit & w_head_entry.write_dst;
  assign rob.commit_free_d_addr = w_commit ? w_head_entry.prev_rw_addr : '0;
  assign rob.commit_free_s      = w_commit & w_head_entry.write_s;
  assign rob.commit_free_s_addr = w_commit ? w_head_entry.prev_rs_addr : '0;

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
// Directed bench for reorder_buffer with L=8: a table of per-cycle input and
// expected-output records, followed by hand-written multi-cycle sequences.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int L = 8;

  logic clk;
  logic rst;

  reorder_buffer_if #(.L(L)) rob_if ();

  reorder_buffer #(.L(L)) dut (
    .clk (clk),
    .rst (rst),
    .rob (rob_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        av;
    logic        wd;
    logic [4:0]  rw;
    logic        ws;
    logic [3:0]  rs;
    logic        cvi;
    logic [2:0]  ca;
    logic        e_rdy;
    logic [2:0]  e_tag;
    logic        e_cv;
    logic        e_fd;
    logic [4:0]  e_fda;
    logic        e_fs;
    logic [3:0]  e_fsa;
    logic        e_emp;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(
    input logic fl, input logic av, input logic wd, input int rw,
    input logic ws, input int rs, input logic cvi, input int ca,
    input logic e_rdy, input int e_tag, input logic e_cv, input logic e_fd,
    input int e_fda, input logic e_fs, input int e_fsa, input logic e_emp,
    input int e_cnt);
    vec_t v;
    v.fl = fl;  v.av = av;  v.wd = wd;  v.rw = rw[4:0];
    v.ws = ws;  v.rs = rs[3:0];  v.cvi = cvi;  v.ca = ca[2:0];
    v.e_rdy = e_rdy;  v.e_tag = e_tag[2:0];  v.e_cv = e_cv;
    v.e_fd = e_fd;  v.e_fda = e_fda[4:0];  v.e_fs = e_fs;
    v.e_fsa = e_fsa[3:0];  v.e_emp = e_emp;  v.e_cnt = e_cnt[3:0];
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    rob_if.flush              = 1'b0;
    rob_if.alloc_valid        = 1'b0;
    rob_if.alloc_write_dst    = 1'b0;
    rob_if.alloc_prev_rw_addr = '0;
    rob_if.alloc_write_s      = 1'b0;
    rob_if.alloc_prev_rs_addr = '0;
    rob_if.complete_valid     = 1'b0;
    rob_if.complete_rob_addr  = '0;
  endtask

  task automatic check_status(input string tag, input logic rdy, input int t,
                              input logic emp, input int cnt);
    chk({tag, ".alloc_ready"}, int'(rob_if.alloc_ready), int'(rdy));
    chk({tag, ".alloc_rob_addr"}, int'(rob_if.alloc_rob_addr), t);
    chk({tag, ".empty"}, int'(rob_if.empty), int'(emp));
    chk({tag, ".count"}, int'(rob_if.count), cnt);
  endtask

  int lat;

  initial begin
    rst = 1'b1;
    drive_idle();

    // ----- vector table (one row per cycle; expectations before the edge) -----
    //              fl av wd rw ws rs cv ca   rdy tag cv fd fda fs fsa emp cnt
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,   1,0, 0,0,0, 0,0, 1,0)); // reset state
    vecs.push_back(mk(0,1,1,5, 0,0, 0,0,   1,0, 0,0,0, 0,0, 1,0));
    vecs.push_back(mk(0,1,1,6, 0,0, 0,0,   1,1, 0,0,0, 0,0, 0,1));
    vecs.push_back(mk(0,1,1,7, 0,0, 0,0,   1,2, 0,0,0, 0,0, 0,2));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,   1,3, 0,0,0, 0,0, 0,3));
    vecs.push_back(mk(0,0,0,0, 0,0, 1,1,   1,3, 0,0,0, 0,0, 0,3)); // done out of order
    vecs.push_back(mk(0,0,0,0, 0,0, 1,0,   1,3, 0,0,0, 0,0, 0,3)); // tag1 waits for head
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,   1,3, 1,1,5, 0,0, 0,3)); // commit tag0
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,   1,3, 1,1,6, 0,0, 0,2)); // commit tag1
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,   1,3, 0,0,0, 0,0, 0,1)); // tag2 stays
    for (int k = 0; k < 7; k++)                                    // fill, tail wraps 7->0
      vecs.push_back(mk(0,1,1,10+k, 0,0, 0,0, 1,(3+k)%8, 0,0,0, 0,0, 0,1+k));
    vecs.push_back(mk(0,1,1,30,0,0, 0,0,   0,2, 0,0,0, 0,0, 0,8)); // full: refused
    vecs.push_back(mk(0,1,1,30,0,0, 1,2,   0,2, 0,0,0, 0,0, 0,8));
    vecs.push_back(mk(0,1,1,30,0,0, 0,0,   0,2, 1,1,7, 0,0, 0,8)); // refused while retiring
    vecs.push_back(mk(0,1,1,20,0,0, 0,0,   1,2, 0,0,0, 0,0, 0,7)); // reuse retired slot
    vecs.push_back(mk(0,0,0,0, 0,0, 1,3,   0,3, 0,0,0, 0,0, 0,8));
    vecs.push_back(mk(0,0,0,0, 0,0, 1,4,   0,3, 1,1,10,0,0, 0,8)); // back-to-back commits
    vecs.push_back(mk(0,0,0,0, 0,0, 1,5,   1,3, 1,1,11,0,0, 0,7));
    vecs.push_back(mk(0,0,0,0, 0,0, 1,6,   1,3, 1,1,12,0,0, 0,6));
    vecs.push_back(mk(0,0,0,0, 0,0, 1,7,   1,3, 1,1,13,0,0, 0,5));
    vecs.push_back(mk(0,1,1,21,0,0, 0,0,   1,3, 1,1,14,0,0, 0,4)); // alloc+commit at 4
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,   1,4, 0,0,0, 0,0, 0,4)); // count unchanged
    vecs.push_back(mk(0,1,1,22,0,0, 1,0,   1,4, 0,0,0, 0,0, 0,4));
    vecs.push_back(mk(1,1,1,23,0,0, 1,1,   1,5, 0,0,0, 0,0, 0,5)); // flush, head done
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,   1,0, 0,0,0, 0,0, 1,0));
    vecs.push_back(mk(0,1,0,9, 1,3, 0,0,   1,0, 0,0,0, 0,0, 1,0)); // S-only entry
    vecs.push_back(mk(0,0,0,0, 0,0, 1,0,   1,1, 0,0,0, 0,0, 0,1));
    vecs.push_back(mk(0,0,0,0, 0,0, 1,0,   1,1, 1,0,0, 1,3, 0,1)); // duplicate complete
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,   1,1, 0,0,0, 0,0, 1,0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      string rn;
      rn = $sformatf("row%0d", i);
      rob_if.flush              = vecs[i].fl;
      rob_if.alloc_valid        = vecs[i].av;
      rob_if.alloc_write_dst    = vecs[i].wd;
      rob_if.alloc_prev_rw_addr = vecs[i].rw;
      rob_if.alloc_write_s      = vecs[i].ws;
      rob_if.alloc_prev_rs_addr = vecs[i].rs;
      rob_if.complete_valid     = vecs[i].cvi;
      rob_if.complete_rob_addr  = vecs[i].ca;
      #1;
      check_status(rn, vecs[i].e_rdy, int'(vecs[i].e_tag), vecs[i].e_emp, int'(vecs[i].e_cnt));
      chk({rn, ".commit_valid"}, int'(rob_if.commit_valid), int'(vecs[i].e_cv));
      chk({rn, ".commit_free_d"}, int'(rob_if.commit_free_d), int'(vecs[i].e_fd));
      chk({rn, ".commit_free_s"}, int'(rob_if.commit_free_s), int'(vecs[i].e_fs));
      if (vecs[i].e_fd)
        chk({rn, ".commit_free_d_addr"}, int'(rob_if.commit_free_d_addr), int'(vecs[i].e_fda));
      if (vecs[i].e_fs)
        chk({rn, ".commit_free_s_addr"}, int'(rob_if.commit_free_s_addr), int'(vecs[i].e_fsa));
      @(negedge clk);
    end
    drive_idle();

    // ----- completion-to-commit latency (state: empty, head=tail=1) -----
    rob_if.alloc_valid        = 1'b1;
    rob_if.alloc_write_dst    = 1'b1;
    rob_if.alloc_prev_rw_addr = 5'd9;
    #1;
    chk("lat.alloc_tag", int'(rob_if.alloc_rob_addr), 1);
    @(negedge clk);
    drive_idle();
    rob_if.complete_valid    = 1'b1;
    rob_if.complete_rob_addr = 3'd1;
    #1;
    chk("lat.no_commit_in_complete_cycle", int'(rob_if.commit_valid), 0);
    @(negedge clk);
    drive_idle();
    lat = -1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      if (rob_if.commit_valid) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    chk("lat.cycles_to_commit", lat, 1);
    chk("lat.free_d_addr", int'(rob_if.commit_free_d_addr), 9);
    @(negedge clk);

    // ----- reset with live entries -----
    rob_if.alloc_valid = 1'b1;
    rob_if.alloc_write_dst = 1'b1;
    rob_if.alloc_prev_rw_addr = 5'd4;
    @(negedge clk);
    @(negedge clk);
    drive_idle();
    #1;
    check_status("prereset", 1'b1, 4, 1'b0, 2);
    @(negedge clk);
    rst = 1'b1;
    rob_if.alloc_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    #1;
    check_status("postreset", 1'b1, 0, 1'b1, 0);
    chk("postreset.commit_valid", int'(rob_if.commit_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
